// File: rtl/dct_pkg.sv
// Shared constants, state encoding and the phase-to-weight mapping for the
// 16-point inverse DCT datapath.
package dct_pkg;

    localparam int BW     = 11;  // signed coefficient width
    localparam int ACC_W  = 21;  // signed accumulator width
    localparam int PIX_W  = 8;   // unsigned output sample width
    localparam int WT_W   = 6;   // signed 1.6 weight width
    localparam int N_PTS  = 16;
    localparam int PROD_W = BW + WT_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COMP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Quarter-wave cosine magnitudes in 1.6 format, indexed by phase 0..16.
    localparam logic signed [WT_W-1:0] W_TABLE [0:16] = '{
        6'sd23, 6'sd23, 6'sd22, 6'sd22, 6'sd21, 6'sd20, 6'sd19, 6'sd17, 6'sd16,
        6'sd14, 6'sd13, 6'sd11, 6'sd9,  6'sd7,  6'sd4,  6'sd2,  6'sd0
    };

    // Signed weight linking coefficient k to output sample n; the DC term
    // carries the fixed weight 16.
    function automatic logic signed [WT_W-1:0] idct_weight(input logic [3:0] k, input int n);
        int p;
        int m;
        logic neg;
        logic signed [WT_W-1:0] w;
        p = (int'(k) * (2 * n + 1)) % 64;
        if (p <= 16) begin
            m = p;       neg = 1'b0;
        end else if (p < 32) begin
            m = 32 - p;  neg = 1'b1;
        end else if (p < 48) begin
            m = p - 32;  neg = 1'b1;
        end else begin
            m = 64 - p;  neg = 1'b0;
        end
        w = neg ? -W_TABLE[m[4:0]] : W_TABLE[m[4:0]];
        if (k == 4'd0) begin
            w = 6'sd16;
        end
        return w;
    endfunction

endpackage

// File: rtl/idct_mac_lane.sv
// One output lane of the inverse DCT: constant weight select for sample N,
// multiply-accumulate over the coefficient stream, then round and clamp.
module idct_mac_lane
    import dct_pkg::*;
#(
    parameter int N = 0
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clear,
    input  logic                    i_en,
    input  logic                    i_load,
    input  logic signed [BW-1:0]    i_coef,
    input  logic [3:0]              i_k,
    output logic [PIX_W-1:0]        o_sample
);

    logic signed [WT_W-1:0]   w_weight;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [ACC_W-1:0]  w_round;
    logic [PIX_W-1:0]         w_sample;
    logic signed [ACC_W-1:0]  r_acc;
    logic [PIX_W-1:0]         r_sample;

    always_comb begin
        w_weight   = idct_weight(i_k, N);
        w_prod     = PROD_W'(i_coef) * PROD_W'(w_weight);
        w_acc_next = r_acc + ACC_W'(w_prod);
        // Round to nearest, then drop the six fractional weight bits.
        w_round    = (w_acc_next + ACC_W'(32)) >>> 6;
        if (w_round < 0) begin
            w_sample = '0;
        end else if (w_round > ACC_W'(255)) begin
            w_sample = '1;
        end else begin
            w_sample = w_round[PIX_W-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_sample <= '0;
        end else begin
            if (i_clear) begin
                r_acc <= '0;
            end else if (i_en) begin
                r_acc <= w_acc_next;
            end
            if (i_load) begin
                r_sample <= w_sample;
            end
        end
    end

    assign o_sample = r_sample;

endmodule

// File: rtl/idct_1d_row_seq.sv
// Sequential 16-point 1-D inverse DCT row pass: one coefficient per cycle is
// broadcast to 16 MAC lanes, with valid/ready handshakes on both sides.
module idct_1d_row_seq
    import dct_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_PTS*BW-1:0]       X_k_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_PTS*PIX_W-1:0]    x_n_out
);

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic [N_PTS*BW-1:0]   r_coef;
    logic signed [BW-1:0]  w_coefs [N_PTS];
    logic signed [BW-1:0]  w_coef;
    logic                  w_accept;
    logic                  w_last;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid && (r_state == ST_IDLE);
    assign w_last    = (r_state == ST_COMP) && (r_cnt == 4'd15);

    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)           w_state_next = ST_COMP;
            ST_COMP: if (r_cnt == 4'd15)     w_state_next = ST_DONE;
            ST_DONE: if (out_ready)          w_state_next = ST_IDLE;
            default:                         w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_coef  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_cnt  <= '0;
                r_coef <= X_k_in;
            end else if ((r_state == ST_COMP) && (r_cnt != 4'd15)) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // X_0 sits in the most significant slice of the packed vector.
    always_comb begin
        for (int k = 0; k < N_PTS; k++) begin
            w_coefs[k] = r_coef[(N_PTS-1-k)*BW +: BW];
        end
        w_coef = w_coefs[r_cnt];
    end

    for (genvar n = 0; n < N_PTS; n++) begin : g_lane
        idct_mac_lane #(.N(n)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_clear  (w_accept),
            .i_en     (r_state == ST_COMP),
            .i_load   (w_last),
            .i_coef   (w_coef),
            .i_k      (r_cnt),
            .o_sample (x_n_out[(N_PTS-1-n)*PIX_W +: PIX_W])
        );
    end

endmodule

// File: tb/tb_idct_1d_row_seq.sv
// Directed bench for idct_1d_row_seq with an in-order scoreboard fed by an
// independent integer reference model of the inverse transform.
module tb_idct_1d_row_seq;

    localparam int WT [17] = '{23, 23, 22, 22, 21, 20, 19, 17, 16, 14, 13, 11, 9, 7, 4, 2, 0};

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [175:0] X_k_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] x_n_out;

    int           n_tests;
    int           n_fail;
    int           cyc;
    logic [127:0] sb [$];

    idct_1d_row_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X_k_in    (X_k_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_n_out   (x_n_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [175:0] v);
        logic [127:0] r;
        logic [10:0]  raw;
        int acc, c, w, p, y;
        r = '0;
        for (int n = 0; n < 16; n++) begin
            acc = 0;
            for (int k = 0; k < 16; k++) begin
                raw = v[(15-k)*11 +: 11];
                c   = $signed(raw);
                p   = (k * (2 * n + 1)) % 64;
                if (k == 0)       w = 16;
                else if (p <= 16) w = WT[p];
                else if (p < 32)  w = -WT[32-p];
                else if (p < 48)  w = -WT[p-32];
                else              w = WT[64-p];
                acc += c * w;
            end
            y = (acc + 32) >>> 6;
            if (y < 0)   y = 0;
            if (y > 255) y = 255;
            r[(15-n)*8 +: 8] = y[7:0];
        end
        return r;
    endfunction

    function automatic logic [175:0] mk(input int x0, input int x1);
        logic [175:0] v;
        v = '0;
        v[175 -: 11] = x0[10:0];
        v[164 -: 11] = x1[10:0];
        return v;
    endfunction

    function automatic logic [175:0] rnd_vec();
        logic [175:0] v;
        logic [10:0]  r;
        for (int k = 0; k < 16; k++) begin
            r = 11'($urandom_range(0, 2047));
            v[(15-k)*11 +: 11] = r;
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a vector, waits for acceptance and records the accept cycle.
    task automatic send(input logic [175:0] v, output int t_acc);
        int n;
        X_k_in   = v;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (!in_ready) check("accept_timeout", in_ready, 1'b1);
        t_acc = cyc;
        sb.push_back(model(v));
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int t_v);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        if (!out_valid) check("out_valid_timeout", out_valid, 1'b1);
        t_v = cyc;
    endtask

    // Output monitor: compares every handshaken result in order.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) check("unexpected_output", out_valid, 1'b0);
            else                check("scoreboard", x_n_out, sb.pop_front());
        end
    end

    initial begin
        int t_a, t_v, t0, t1, t2, n;
        logic [175:0] v;
        logic [127:0] exp_v;
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        X_k_in    = '0;
        repeat (3) step();
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_x_n_out", x_n_out, 128'd0);
        rst = 1'b0;
        step();

        send(mk(0, 0), t_a);
        wait_valid(t_v);
        check("zero_latency", t_v - t_a, 17);
        check("zero_data", x_n_out, 128'd0);
        step();

        send(mk(512, 0), t_a);
        wait_valid(t_v);
        check("dc512_data", x_n_out, {16{8'd128}});
        step();

        send(mk(1020, 0), t_a);
        wait_valid(t_v);
        check("dc1020_clamp_hi", x_n_out, {16{8'd255}});
        step();

        send(mk(-100, 0), t_a);
        wait_valid(t_v);
        check("dcneg_clamp_lo", x_n_out, 128'd0);
        step();

        send(mk(512, 100), t_a);
        wait_valid(t_v);
        check("x1_sample0", x_n_out[127:120], 8'd164);
        check("x1_sample15", x_n_out[7:0], 8'd92);
        step();

        repeat (3) begin
            send(rnd_vec(), t_a);
            wait_valid(t_v);
            check("rand_latency", t_v - t_a, 17);
            step();
        end

        // Downstream stall: data and handshakes must hold.
        out_ready = 1'b0;
        v = mk(300, -200);
        exp_v = model(v);
        send(v, t_a);
        wait_valid(t_v);
        for (int i = 0; i < 5; i++) begin
            check("stall_data", x_n_out, exp_v);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_out_valid", out_valid, 1'b1);
            step();
        end
        out_ready = 1'b1;
        step();
        check("release_in_ready", in_ready, 1'b1);
        check("release_out_valid", out_valid, 1'b0);

        // Reset in the 8th compute cycle, with a new vector offered alongside.
        send(mk(700, 50), t_a);
        repeat (7) step();
        rst      = 1'b1;
        in_valid = 1'b1;
        X_k_in   = mk(512, 0);
        step();
        void'(sb.pop_back());
        check("midreset_in_ready", in_ready, 1'b1);
        check("midreset_out_valid", out_valid, 1'b0);
        check("midreset_x_n_out", x_n_out, 128'd0);
        rst = 1'b0;
        send(mk(512, 0), t_a);
        wait_valid(t_v);
        check("postreset_latency", t_v - t_a, 17);
        check("postreset_data", x_n_out, {16{8'd128}});
        step();

        // Back-to-back with in_valid held high and out_ready tied high.
        send(rnd_vec(), t0);
        send(rnd_vec(), t1);
        send(rnd_vec(), t2);
        check("b2b_gap1", t1 - t0, 18);
        check("b2b_gap2", t2 - t1, 18);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
